// File: rtl/stopwatch_pkg.sv
// Shared definitions for the stopwatch: field limits, mode encoding, the
// 24-bit {hours, minutes, seconds} layout and the time arithmetic helpers.
package stopwatch_pkg;

  localparam logic [7:0] SEC_MAX = 8'd59;
  localparam logic [7:0] MIN_MAX = 8'd59;

  localparam logic MODE_UP   = 1'b0;
  localparam logic MODE_DOWN = 1'b1;

  // Bit layout matches load_time / lap_time: [23:16] hh, [15:8] mm, [7:0] ss.
  typedef struct packed {
    logic [7:0] hh;
    logic [7:0] mm;
    logic [7:0] ss;
  } time_t;

  function automatic logic [7:0] clamp8(input logic [7:0] v, input logic [7:0] lim);
    return (v > lim) ? lim : v;
  endfunction

  function automatic time_t time_clamp(input time_t t, input logic [7:0] hmax);
    time_t r;
    r.hh = clamp8(t.hh, hmax);
    r.mm = clamp8(t.mm, MIN_MAX);
    r.ss = clamp8(t.ss, SEC_MAX);
    return r;
  endfunction

  // Full carry chain resolves in one step, so HOURS_MAX:59:59 goes straight to 0.
  function automatic time_t time_inc(input time_t t, input logic [7:0] hmax);
    time_t r;
    r = t;
    if (t.ss != SEC_MAX) r.ss = t.ss + 8'd1;
    else begin
      r.ss = '0;
      if (t.mm != MIN_MAX) r.mm = t.mm + 8'd1;
      else begin
        r.mm = '0;
        r.hh = (t.hh >= hmax) ? 8'd0 : t.hh + 8'd1;
      end
    end
    return r;
  endfunction

  // Caller guarantees t != 0.
  function automatic time_t time_dec(input time_t t);
    time_t r;
    r = t;
    if (t.ss != 8'd0) r.ss = t.ss - 8'd1;
    else begin
      r.ss = SEC_MAX;
      if (t.mm != 8'd0) r.mm = t.mm - 8'd1;
      else begin
        r.mm = MIN_MAX;
        r.hh = t.hh - 8'd1;
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/stopwatch_tick_divider.sv
// tick_divider: free-running prescaler that pulses tick for one cycle every
// TICKS_PER_SEC enabled cycles. Holds its count while enable is low.
// Ports: clock, reset (sync active-low, also used as a clear), enable, tick.
module tick_divider #(
  parameter int TICKS_PER_SEC = 25000000
) (
  input  logic clock,
  input  logic reset,
  input  logic enable,
  output logic tick
);
  localparam int CW = (TICKS_PER_SEC > 2) ? $clog2(TICKS_PER_SEC) : 1;
  localparam logic [CW-1:0] LAST = CW'(TICKS_PER_SEC - 1);

  logic [CW-1:0] cnt;

  assign tick = enable && (cnt == LAST);

  always_ff @(posedge clock) begin
    if (!reset)      cnt <= '0;
    else if (tick)   cnt <= '0;
    else if (enable) cnt <= cnt + 1'b1;
  end
endmodule

// File: rtl/stopwatch_timer.sv
// stopwatch_timer: up/down hh:mm:ss stopwatch with load, countdown expiry
// and optional lap capture (enable with `define STOPWATCH_LAP_EN).
// Ports: clock, reset (sync active-low), start_stop (level, rising edge
// toggles run), mode (0 up / 1 down), load + load_time {hh,mm,ss},
// lap pulse; outputs seconds/minutes/hours, running, expired (sticky),
// lap_time {hh,mm,ss}, lap_valid (one-cycle pulse).
module stopwatch_timer
  import stopwatch_pkg::*;
#(
  parameter int TICKS_PER_SEC = 25000000,
  parameter int HOURS_MAX     = 99
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        start_stop,
  input  logic        mode,
  input  logic        load,
  input  logic [23:0] load_time,
  input  logic        lap,
  output logic [7:0]  seconds,
  output logic [7:0]  minutes,
  output logic [7:0]  hours,
  output logic        running,
  output logic        expired,
  output logic [23:0] lap_time,
  output logic        lap_valid
);
  localparam logic [7:0] HMAX = 8'(HOURS_MAX);

  time_t cur, nxt_t;
  logic  ss_q, run_q, exp_q, nxt_run, nxt_exp;
  logic  ss_edge, at_zero, sec_tick;

  // Load restarts the partial second by clearing the prescaler.
  tick_divider #(.TICKS_PER_SEC(TICKS_PER_SEC)) u_div (
    .clock  (clock),
    .reset  (reset & ~load),
    .enable (run_q),
    .tick   (sec_tick)
  );

  assign ss_edge = start_stop & ~ss_q;
  assign at_zero = (cur == '0);

  always_comb begin
    nxt_t   = cur;
    nxt_run = run_q;
    nxt_exp = exp_q;
    // An exhausted countdown cannot be restarted until reloaded.
    if (ss_edge && !(mode == MODE_DOWN && at_zero)) nxt_run = ~run_q;
    if (load) begin
      nxt_t   = time_clamp(time_t'(load_time), HMAX);
      nxt_exp = 1'b0;
    end else if (sec_tick) begin
      if (mode == MODE_UP) nxt_t = time_inc(cur, HMAX);
      else begin
        if (!at_zero) nxt_t = time_dec(cur);
        // Expiry overrides any coincident start_stop toggle.
        if (nxt_t == '0) begin
          nxt_run = 1'b0;
          nxt_exp = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      cur   <= '0;
      run_q <= 1'b0;
      exp_q <= 1'b0;
      ss_q  <= start_stop;
    end else begin
      cur   <= nxt_t;
      run_q <= nxt_run;
      exp_q <= nxt_exp;
      ss_q  <= start_stop;
    end
  end

  assign seconds = cur.ss;
  assign minutes = cur.mm;
  assign hours   = cur.hh;
  assign running = run_q;
  assign expired = exp_q;

`ifdef STOPWATCH_LAP_EN
  time_t lap_q;
  logic  lap_v;

  // Captures the time as it stands before this cycle's update.
  always_ff @(posedge clock) begin
    if (!reset) begin
      lap_q <= '0;
      lap_v <= 1'b0;
    end else begin
      lap_v <= lap;
      if (lap) lap_q <= cur;
    end
  end

  assign lap_time  = lap_q;
  assign lap_valid = lap_v;
`else
  logic unused_lap;
  assign unused_lap = lap;
  assign lap_time   = '0;
  assign lap_valid  = 1'b0;
`endif
endmodule

// File: tb/tb_stopwatch_timer.sv
// Randomized + directed bench for stopwatch_timer. The reference model keeps
// time as a total-seconds integer and the prescaler as a phase count.
module tb_stopwatch_timer;
  localparam int T   = 4;
  localparam int HM  = 99;
  localparam int MOD = (HM + 1) * 3600;

  logic        clock, reset, start_stop, mode, load, lap;
  logic [23:0] load_time;
  logic [7:0]  seconds, minutes, hours;
  logic        running, expired, lap_valid;
  logic [23:0] lap_time;

  stopwatch_timer #(.TICKS_PER_SEC(T), .HOURS_MAX(HM)) dut (
    .clock(clock), .reset(reset), .start_stop(start_stop), .mode(mode),
    .load(load), .load_time(load_time), .lap(lap),
    .seconds(seconds), .minutes(minutes), .hours(hours),
    .running(running), .expired(expired),
    .lap_time(lap_time), .lap_valid(lap_valid)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

`ifdef STOPWATCH_LAP_EN
  localparam bit LAPEN = 1'b1;
`else
  localparam bit LAPEN = 1'b0;
`endif

  int n_cmp = 0;
  int n_bad = 0;
  int cyc_no = 0;

  // model state
  int m_t, m_pre, m_lapt;
  bit m_run, m_exp, m_ssp, m_lapv;

  function automatic logic [23:0] enc(input int t);
    logic [7:0] h, m, s;
    h = 8'(t / 3600);
    m = 8'((t / 60) % 60);
    s = 8'(t % 60);
    return {h, m, s};
  endfunction

  function automatic int clampv(input int v, input int lim);
    return (v > lim) ? lim : v;
  endfunction

  task automatic model_step(input bit r, input bit s, input bit md, input bit ld,
                            input logic [23:0] lt, input bit lp);
    bit edge_s, tick;
    int nt, npre;
    bit nrun, nexp;
    if (!r) begin
      m_t = 0; m_pre = 0; m_run = 0; m_exp = 0; m_ssp = s; m_lapt = 0; m_lapv = 0;
      return;
    end
    edge_s = s && !m_ssp;
    m_ssp  = s;
    tick   = m_run && (m_pre == T - 1);
    nt = m_t; nrun = m_run; nexp = m_exp;
    npre = m_run ? (m_pre + 1) % T : m_pre;
    if (edge_s && !(md && m_t == 0)) nrun = !nrun;
    if (ld) begin
      nt = clampv(int'(lt[23:16]), HM) * 3600 + clampv(int'(lt[15:8]), 59) * 60
           + clampv(int'(lt[7:0]), 59);
      nexp = 0;
      npre = 0;
    end else if (tick) begin
      if (!md) nt = (m_t + 1) % MOD;
      else begin
        nt = (m_t > 0) ? m_t - 1 : 0;
        if (nt == 0) begin nrun = 0; nexp = 1; end
      end
    end
    if (LAPEN) begin
      m_lapv = lp;
      if (lp) m_lapt = m_t;
    end
    m_t = nt; m_pre = npre; m_run = nrun; m_exp = nexp;
  endtask

  task automatic chk(input string name, input int got, input int exp_v);
    n_cmp++;
    if (got != exp_v) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp_v);
    end
  endtask

  task automatic cyc(input bit r, input bit s, input bit md, input bit ld,
                     input logic [23:0] lt, input bit lp);
    logic [57:0] got, expv;
    reset = r; start_stop = s; mode = md; load = ld; load_time = lt; lap = lp;
    model_step(r, s, md, ld, lt, lp);
    @(posedge clock);
    #1;
    cyc_no++;
    got  = {hours, minutes, seconds, running, expired, lap_time, lap_valid};
    expv = {enc(m_t), m_run, m_exp, enc(m_lapt), m_lapv};
    n_cmp++;
    if (got !== expv) begin
      n_bad++;
      $display("FAIL cycle %0d: got hms=%0d:%0d:%0d run=%b exp=%b lap=%h lv=%b expected %h",
               cyc_no, hours, minutes, seconds, running, expired, lap_time, lap_valid, expv);
    end
  endtask

  bit ss_r, md_r;

  initial begin
    // reset
    cyc(0, 0, 0, 0, 24'h0, 0);
    cyc(0, 0, 0, 0, 24'h0, 0);
    chk("reset_time", int'({hours, minutes, seconds}), 0);
    chk("reset_run", int'(running), 0);

    // one start edge, 8 cycles up
    cyc(1, 1, 0, 0, 24'h0, 0);
    for (int i = 0; i < 8; i++) cyc(1, 1, 0, 0, 24'h0, 0);
    chk("up_sec2", int'(seconds), 2);
    chk("up_running", int'(running), 1);

    // 99:59:58 wraps to zero
    cyc(1, 1, 0, 1, {8'd99, 8'd59, 8'd58}, 0);
    for (int i = 0; i < 8; i++) begin
      cyc(1, 1, 0, 0, 24'h0, 0);
      chk("no_h100", int'(hours <= 8'd99), 1);
    end
    chk("wrap_zero", int'({hours, minutes, seconds}), 0);

    // countdown to expiry
    cyc(1, 1, 1, 1, {8'd0, 8'd0, 8'd2}, 0);
    for (int i = 0; i < 8; i++) cyc(1, 1, 1, 0, 24'h0, 0);
    chk("dn_zero", int'({hours, minutes, seconds}), 0);
    chk("dn_stopped", int'(running), 0);
    chk("dn_expired", int'(expired), 1);
    cyc(1, 0, 1, 0, 24'h0, 0);
    cyc(1, 1, 1, 0, 24'h0, 0);
    chk("dn_edge_ignored", int'(running), 0);
    cyc(1, 1, 1, 1, {8'd0, 8'd1, 8'd0}, 0);
    chk("load_clr_exp", int'(expired), 0);

    // borrow across minutes
    cyc(1, 0, 1, 0, 24'h0, 0);
    cyc(1, 1, 1, 0, 24'h0, 0);
    for (int i = 0; i < 4; i++) cyc(1, 1, 1, 0, 24'h0, 0);
    chk("borrow", int'({hours, minutes, seconds}), int'({8'd0, 8'd0, 8'd59}));

    // clamping; then load coincident with tick
    cyc(1, 1, 0, 1, {8'd0, 8'd75, 8'd80}, 0);
    chk("clamp", int'({hours, minutes, seconds}), int'({8'd0, 8'd59, 8'd59}));
    for (int i = 0; i < 3; i++) cyc(1, 1, 0, 0, 24'h0, 0);
    cyc(1, 1, 0, 1, {8'd1, 8'd2, 8'd3}, 0);
    chk("load_beats_tick", int'({hours, minutes, seconds}), int'({8'd1, 8'd2, 8'd3}));

    // lap coincident with tick, then reset mid-count
    cyc(1, 1, 0, 1, {8'd0, 8'd0, 8'd5}, 0);
    for (int i = 0; i < 3; i++) cyc(1, 1, 0, 0, 24'h0, 0);
    cyc(1, 1, 0, 0, 24'h0, 1);
    chk("lap_time_now", int'(seconds), 6);
    chk("lap_time", int'(lap_time), LAPEN ? 5 : 0);
    chk("lap_valid", int'(lap_valid), LAPEN ? 1 : 0);
    cyc(1, 1, 0, 0, 24'h0, 0);
    cyc(0, 1, 0, 0, 24'h0, 0);
    chk("rst_all", int'({hours, minutes, seconds, running, expired, lap_time, lap_valid}), 0);

    // randomized run
    ss_r = 1; md_r = 0;
    for (int i = 0; i < 3000; i++) begin
      bit r, ld, lp;
      logic [23:0] lt;
      r  = ($urandom_range(0, 299) != 0);
      ld = ($urandom_range(0, 39) == 0);
      lp = ($urandom_range(0, 7) == 0);
      if ($urandom_range(0, 5) == 0) ss_r = !ss_r;
      if ($urandom_range(0, 49) == 0) md_r = !md_r;
      lt = ($urandom_range(0, 1) == 0) ? 24'($urandom)
           : {8'($urandom_range(0, 99)), 8'($urandom_range(0, 59)), 8'($urandom_range(0, 59))};
      if ($urandom_range(0, 9) == 0) lt = {8'd0, 8'd0, 8'($urandom_range(0, 3))};
      cyc(r, ss_r, md_r, ld, lt, lp);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/stopwatch_timer.md
STOPWATCH_TIMER -- requirements
Module: stopwatch_timer

Interface
REQ-001 SHALL have parameter TICKS_PER_SEC, default 25000000, clock cycles per counted second (minimum 2).
REQ-002 SHALL have parameter HOURS_MAX, default 99, highest hours value before wrap (1..255).
REQ-003 SHALL have port clock, input, 1, sole clock; all logic on its rising edge.
REQ-004 SHALL have port reset, input, 1, synchronous active-low reset.
REQ-005 SHALL have port start_stop, input, 1, level; each rising edge toggles run state.
REQ-006 SHALL have port mode, input, 1, 0 = count up, 1 = count down.
REQ-007 SHALL have port load, input, 1, single-cycle pulse loading load_time.
REQ-008 SHALL have port load_time, input, 24, {hours, minutes, seconds}, 8 bits each, binary.
REQ-009 SHALL have port lap, input, 1, single-cycle pulse capturing current time.
REQ-010 SHALL have ports seconds, minutes and hours, output, 8 each, current time, binary.
REQ-011 SHALL have port running, output, 1, counting active.
REQ-012 SHALL have port expired, output, 1, sticky countdown-reached-zero flag.
REQ-013 SHALL have port lap_time, output, 24, captured {hours, minutes, seconds}.
REQ-014 SHALL have port lap_valid, output, 1, one-cycle pulse on capture.

Function
REQ-015 SHALL register start_stop and detect rising edges internally; the first cycle after reset never counts as an edge.
REQ-016 SHALL advance the prescaler only while running, wrapping TICKS_PER_SEC-1 -> 0 and issuing a one-cycle sec_tick at the wrap; the prescaler holds while stopped.
REQ-017 Up mode: each sec_tick SHALL increment seconds; 59 -> 0 carries into minutes; minutes 59 -> 0 carries into hours; hours HOURS_MAX -> 0; all carries resolve in the same cycle (99:59:59 -> 00:00:00).
REQ-018 Down mode: each sec_tick SHALL decrement seconds with borrow (seconds 0 -> 59, minutes 0 -> 59, hours decrement).
REQ-019 Down mode: on the cycle the time becomes 00:00:00, running SHALL clear and expired SHALL set; the time holds at zero.
REQ-020 In down mode with time 00:00:00, a start_stop edge SHALL be ignored.
REQ-021 expired SHALL clear only on load or reset.
REQ-022 load SHALL copy load_time into the time, clamping seconds and minutes to 59 and hours to HOURS_MAX, clear the prescaler, and clear expired; running is unchanged.
REQ-023 load SHALL take priority over a coincident sec_tick.
REQ-024 mode SHALL be sampled at each sec_tick; a mode change never alters the time by itself.
REQ-025 When a start_stop edge coincides with sec_tick, the tick SHALL still apply; the run state toggles in the same cycle.
REQ-026 Time-output latency SHALL be one cycle from sec_tick or load.

Reset
REQ-027 When reset is low at a clock edge, the block SHALL set time to 00:00:00, prescaler to 0, running to 0, expired to 0, lap_time to 0, lap_valid to 0, and the start_stop history register to the current start_stop value.
REQ-028 Reset mid-count SHALL discard the partial second.

Configuration
REQ-029 With STOPWATCH_LAP_EN defined, lap SHALL capture the pre-update time of that cycle into lap_time, with lap_valid high the next cycle.
REQ-030 With STOPWATCH_LAP_EN undefined, lap SHALL be ignored and lap_time and lap_valid SHALL be tied to 0.

Structure
REQ-031 Package stopwatch_pkg SHALL hold SEC_MAX = 59, MIN_MAX = 59, the mode encoding constants MODE_UP and MODE_DOWN, and the 24-bit time-field layout.
REQ-032 Prescaler SHALL be sub-module tick_divider (parameter TICKS_PER_SEC; inputs clock, reset, enable; output tick); its counter width is derived from TICKS_PER_SEC.

Verification (TICKS_PER_SEC = 4, HOURS_MAX = 99)
REQ-033 Reset, then one start_stop edge, then 8 cycles in up mode -> seconds = 2, running = 1.
REQ-034 Load 99:59:58, up mode, running, 8 cycles -> 00:00:00 with no glitch through 100:00:00.
REQ-035 Load 00:00:02, down mode, running, 8 cycles -> 00:00:00, running = 0, expired = 1; a further start_stop edge -> still stopped; a load -> expired = 0.
REQ-036 Load 00:01:00, down mode, first tick -> 00:00:59.
REQ-037 Load 00:75:80 -> 00:59:59 after clamping; load coincident with sec_tick -> loaded value wins.
REQ-038 With STOPWATCH_LAP_EN defined, lap coincident with tick at 00:00:05 -> lap_time = 00:00:05 and time = 00:00:06; reset low mid-count -> all outputs 0 next cycle.
